// File: rtl/mux_rr_sel_ctrl_if.sv
// Request/select bundle between the round-robin select controller and its requesters.
// The slave side is the controller; the master side drives requests and observes the grant.
interface mux_rr_sel_ctrl_if;
  logic [3:0] req;
  logic [1:0] sel;
  logic [3:0] gnt;
  logic       busy;
  logic       out_valid;

  modport slave  (input  req, output sel, output gnt, output busy, output out_valid);
  modport master (output req, input  sel, input  gnt, input  busy, input  out_valid);
endinterface

// File: rtl/mux_rr_sel_ctrl.sv
// Round-robin select controller for a downstream 4:1 registered mux.
// It grants one source for at most HOLD_CYCLES cycles, then rotates priority past the last winner.
module mux_rr_sel_ctrl #(
  parameter int HOLD_CYCLES = 4
) (
  input  logic               clk,
  input  logic               reset,
  mux_rr_sel_ctrl_if.slave   bus
);

  typedef enum logic {S_IDLE, S_GRANT} state_t;

  state_t     r_state;
  logic [1:0] r_lp;
  logic [3:0] r_cnt;
  logic [1:0] r_sel;
  logic [3:0] r_gnt;
  logic       r_busy;
  logic       r_out_valid;

  logic       w_any;
  logic [1:0] w_win;
  logic       w_release;

  // Scan lp+4 down to lp+1 so that the nearest requester after lp is the one kept.
  function automatic logic [1:0] rr_pick(input logic [3:0] rq, input logic [1:0] lp);
    logic [1:0] idx;
    rr_pick = lp;
    for (int k = 4; k >= 1; k--) begin
      idx = lp + 2'(k);
      if (rq[idx]) rr_pick = idx;
    end
  endfunction

  always_comb begin
    w_any     = |bus.req;
    w_win     = rr_pick(bus.req, r_lp);
    w_release = (!bus.req[r_sel]) || (r_cnt == 4'(HOLD_CYCLES));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_lp        <= 2'b11;
      r_cnt       <= 4'd0;
      r_sel       <= 2'b00;
      r_gnt       <= 4'b0000;
      r_busy      <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= r_busy;
      if (r_state == S_GRANT && !w_release) begin
        r_cnt <= r_cnt + 4'd1;
      end else if (w_any) begin
        // Entry from IDLE and release with pending requests share the same back-to-back grant.
        r_state <= S_GRANT;
        r_lp    <= w_win;
        r_sel   <= w_win;
        r_gnt   <= 4'b0001 << w_win;
        r_busy  <= 1'b1;
        r_cnt   <= 4'd1;
      end else begin
        r_state <= S_IDLE;
        r_gnt   <= 4'b0000;
        r_busy  <= 1'b0;
        r_cnt   <= 4'd0;
      end
    end
  end

  assign bus.sel       = r_sel;
  assign bus.gnt       = r_gnt;
  assign bus.busy      = r_busy;
  assign bus.out_valid = r_out_valid;

endmodule

// File: tb/tb_mux_rr_sel_ctrl.sv
// Directed bench for mux_rr_sel_ctrl with HOLD_CYCLES=4 and per-cycle invariant monitoring.
module tb_mux_rr_sel_ctrl;
  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;
  logic mon_en;
  logic exp_ov;

  mux_rr_sel_ctrl_if bus();

  mux_rr_sel_ctrl #(.HOLD_CYCLES(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [3:0] g, input logic [1:0] s,
                         input logic b, input logic ov, input logic [3:0] c);
    chk({tag, ".gnt"}, 32'(bus.gnt), 32'(g));
    chk({tag, ".sel"}, 32'(bus.sel), 32'(s));
    chk({tag, ".busy"}, 32'(bus.busy), 32'(b));
    chk({tag, ".ov"}, 32'(bus.out_valid), 32'(ov));
    chk({tag, ".cnt"}, 32'(dut.r_cnt), 32'(c));
  endtask

  // Expected out_valid: previous busy, forced low by reset.
  always @(posedge clk) exp_ov <= reset ? 1'b0 : bus.busy;

  always @(negedge clk) begin
    if (mon_en) begin
      chk("inv.onehot0", 32'($onehot0(bus.gnt)), 32'd1);
      chk("inv.busy_or", 32'(bus.busy), 32'(|bus.gnt));
      chk("inv.gnt_sel", 32'(bus.gnt[bus.sel]), 32'(bus.busy));
      chk("inv.ov", 32'(bus.out_valid), 32'(exp_ov));
      chk("inv.cnt_max", 32'(dut.r_cnt <= 4'd4), 32'd1);
    end
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    mon_en   = 1'b0;
    reset    = 1'b1;
    bus.req  = 4'b0000;
    tick();
    tick();
    mon_en = 1'b1;
    chk_out("rst", 4'b0000, 2'd0, 1'b0, 1'b0, 4'd0);
    chk("rst.lp", 32'(dut.r_lp), 32'd3);

    // All sources requesting: rotate 0,1,2,3,0 each held 4 cycles.
    reset   = 1'b0;
    bus.req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      for (int c = 1; c <= 4; c++) begin
        tick();
        chk_out($sformatf("rr_g%0d_c%0d", g, c), 4'b0001 << (g % 4), 2'(g % 4), 1'b1,
                (g == 0 && c == 1) ? 1'b0 : 1'b1, 4'(c));
      end
    end
    bus.req = 4'b0000;
    tick();
    chk_out("rr_idle", 4'b0000, 2'd0, 1'b0, 1'b1, 4'd0);
    tick();
    chk_out("rr_idle2", 4'b0000, 2'd0, 1'b0, 1'b0, 4'd0);

    // Single short request from source 2, then idle with sel held.
    bus.req = 4'b0100;
    tick();
    chk_out("s2_c1", 4'b0100, 2'd2, 1'b1, 1'b0, 4'd1);
    tick();
    chk_out("s2_c2", 4'b0100, 2'd2, 1'b1, 1'b1, 4'd2);
    bus.req = 4'b0000;
    tick();
    chk_out("s2_rel", 4'b0000, 2'd2, 1'b0, 1'b1, 4'd0);
    tick();
    chk_out("s2_idle", 4'b0000, 2'd2, 1'b0, 1'b0, 4'd0);

    // Sole requester 1 keeps the grant continuously; cnt restarts after each hold.
    bus.req = 4'b0010;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk_out($sformatf("sole_%0d", i), 4'b0010, 2'd1, 1'b1, (i == 0) ? 1'b0 : 1'b1,
              4'((i % 4) + 1));
    end

    // Holder drops out: back-to-back grant to 3, then 0 after 3 leaves.
    bus.req = 4'b1001;
    tick();
    chk_out("b2b_s3", 4'b1000, 2'd3, 1'b1, 1'b1, 4'd1);
    tick();
    chk_out("b2b_s3_h", 4'b1000, 2'd3, 1'b1, 1'b1, 4'd2);
    bus.req = 4'b0001;
    tick();
    chk_out("b2b_s0", 4'b0001, 2'd0, 1'b1, 1'b1, 4'd1);

    // Reset in the second cycle of a grant to source 2.
    bus.req = 4'b0100;
    tick();
    chk_out("mr_s2_c1", 4'b0100, 2'd2, 1'b1, 1'b1, 4'd1);
    tick();
    chk_out("mr_s2_c2", 4'b0100, 2'd2, 1'b1, 1'b1, 4'd2);
    reset   = 1'b1;
    bus.req = 4'b1111;
    tick();
    chk_out("mr_rst", 4'b0000, 2'd0, 1'b0, 1'b0, 4'd0);
    chk("mr_rst.lp", 32'(dut.r_lp), 32'd3);
    reset = 1'b0;
    tick();
    chk_out("mr_first", 4'b0001, 2'd0, 1'b1, 1'b0, 4'd1);
    tick();
    chk_out("mr_second", 4'b0001, 2'd0, 1'b1, 1'b1, 4'd2);

    @(negedge clk);
    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout got %0d expected %0d", 0, 1);
    $fatal(1, "timeout");
  end
endmodule
